// File: rtl/mor1kx_wb_pkg.sv
// Shared types and defaults for the mor1kx two-master Wishbone arbiter.
package mor1kx_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  localparam int WB_AW      = 32;
  localparam int WB_DW      = 32;
  localparam int WB_TIMEOUT = 255;

endpackage

// File: rtl/mor1kx_wb_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and pulses timeout on reaching TIMEOUT.
module mor1kx_wb_watchdog
  import mor1kx_wb_pkg::*;
#(
  parameter int TIMEOUT = WB_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // The pulse needs en so that a slave response in the same cycle wins.
  assign timeout = en && (cnt == CW'(TIMEOUT));

  // Stall counter; self-clears on the timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CW{1'b0}};
    end else if (clr || timeout) begin
      cnt <= {CW{1'b0}};
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/mor1kx_wb_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone B3 classic arbiter
// with round-robin grant, cycle locking and a hung-slave watchdog.
module mor1kx_wb_arbiter
  import mor1kx_wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = WB_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_cyc_i,
  input  logic            i_stb_i,
  input  logic [AW-1:0]   i_adr_i,
  output logic [DW-1:0]   i_dat_o,
  output logic            i_ack_o,
  output logic            i_err_o,
  input  logic            d_cyc_i,
  input  logic            d_stb_i,
  input  logic            d_we_i,
  input  logic [DW/8-1:0] d_sel_i,
  input  logic [AW-1:0]   d_adr_i,
  input  logic [DW-1:0]   d_dat_i,
  output logic [DW-1:0]   d_dat_o,
  output logic            d_ack_o,
  output logic            d_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  state_e state, state_next;
  logic   last_d, last_d_next;
  logic   own_cyc, own_stb;
  logic   wd_en, wd_clr, timeout;

  assign i_dat_o = s_dat_i;
  assign d_dat_o = s_dat_i;

  // State and round-robin history; reset leaves "data" as last served so instr wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state  <= state_next;
      last_d <= last_d_next;
    end
  end

  // Next-state: an owner keeps the bus for its whole cycle, and always hands back via IDLE.
  always_comb begin
    state_next  = state;
    last_d_next = last_d;
    case (state)
      IDLE: begin
        if (i_cyc_i && d_cyc_i) begin
          state_next = last_d ? GNT_I : GNT_D;
        end else if (i_cyc_i) begin
          state_next = GNT_I;
        end else if (d_cyc_i) begin
          state_next = GNT_D;
        end else begin
          state_next = IDLE;
        end
      end
      GNT_I: begin
        if (!i_cyc_i) begin
          state_next  = IDLE;
          last_d_next = 1'b0;
        end else begin
          state_next = GNT_I;
        end
      end
      GNT_D: begin
        if (!d_cyc_i) begin
          state_next  = IDLE;
          last_d_next = 1'b1;
        end else begin
          state_next = GNT_D;
        end
      end
      default: begin
        state_next  = IDLE;
        last_d_next = 1'b1;
      end
    endcase
  end

  // Cycle/strobe of whichever master owns the bus, before watchdog masking.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    case (state)
      GNT_I: begin
        own_cyc = i_cyc_i;
        own_stb = i_stb_i;
      end
      GNT_D: begin
        own_cyc = d_cyc_i;
        own_stb = d_stb_i;
      end
      default: begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
      end
    endcase
  end

  assign wd_en  = own_cyc && own_stb && !s_ack_i && !s_err_i;
  assign wd_clr = (state == IDLE) || (own_cyc && (s_ack_i || s_err_i));

  mor1kx_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .timeout (timeout)
  );

  // Slave-side mux and response routing; err beats ack, late responses are dropped.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = {(DW/8){1'b0}};
    s_adr_o = {AW{1'b0}};
    s_dat_o = {DW{1'b0}};
    i_ack_o = 1'b0;
    i_err_o = 1'b0;
    d_ack_o = 1'b0;
    d_err_o = 1'b0;
    grant_o = GRANT_NONE;
    case (state)
      GNT_I: begin
        grant_o = GRANT_I;
        s_cyc_o = i_cyc_i;
        s_stb_o = i_stb_i && !timeout;
        s_we_o  = 1'b0;
        s_sel_o = {(DW/8){1'b1}};
        s_adr_o = i_adr_i;
        s_dat_o = {DW{1'b0}};
        i_ack_o = i_cyc_i && s_ack_i && !s_err_i;
        i_err_o = (i_cyc_i && s_err_i) || timeout;
      end
      GNT_D: begin
        grant_o = GRANT_D;
        s_cyc_o = d_cyc_i;
        s_stb_o = d_stb_i && !timeout;
        s_we_o  = d_we_i;
        s_sel_o = d_sel_i;
        s_adr_o = d_adr_i;
        s_dat_o = d_dat_i;
        d_ack_o = d_cyc_i && s_ack_i && !s_err_i;
        d_err_o = (d_cyc_i && s_err_i) || timeout;
      end
      default: begin
        grant_o = GRANT_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_mor1kx_wb_arbiter.sv
// Directed self-checking bench for mor1kx_wb_arbiter (TIMEOUT = 4).
module tb_mor1kx_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_cyc_i, i_stb_i;
  logic [AW-1:0]   i_adr_i;
  logic [DW-1:0]   i_dat_o;
  logic            i_ack_o, i_err_o;
  logic            d_cyc_i, d_stb_i, d_we_i;
  logic [DW/8-1:0] d_sel_i;
  logic [AW-1:0]   d_adr_i;
  logic [DW-1:0]   d_dat_i, d_dat_o;
  logic            d_ack_o, d_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [DW/8-1:0] s_sel_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o, s_dat_i;
  logic            s_ack_i, s_err_i;
  logic [1:0]      grant_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mor1kx_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_adr_i(i_adr_i),
    .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_dat_o(d_dat_o),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_cyc_i = 1'b0; i_stb_i = 1'b0; i_adr_i = 32'h0;
    d_cyc_i = 1'b0; d_stb_i = 1'b0; d_we_i = 1'b0; d_sel_i = 4'h0;
    d_adr_i = 32'h0; d_dat_i = 32'h0;
    s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0;
    tick(); tick();
    #1;
    chk("reset_grant", grant_o, 2'b00);
    chk("reset_s_cyc", s_cyc_o, 1'b0);
    chk("reset_i_ack", i_ack_o, 1'b0);
    chk("reset_d_err", d_err_o, 1'b0);
    rst_n = 1'b1;

    // Single instruction read, slave acks one cycle after strobe.
    tick();
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h0000_0040;
    #1;
    chk("t1_latency_grant", grant_o, 2'b00);
    chk("t1_latency_s_cyc", s_cyc_o, 1'b0);
    tick();
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_s_stb", s_stb_o, 1'b1);
    chk("t1_s_adr", s_adr_o, 32'h0000_0040);
    chk("t1_s_we", s_we_o, 1'b0);
    chk("t1_s_sel", s_sel_o, 4'hF);
    chk("t1_s_dat", s_dat_o, 32'h0);
    chk("t1_no_early_ack", i_ack_o, 1'b0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    #1;
    chk("t1_i_ack", i_ack_o, 1'b1);
    chk("t1_i_dat", i_dat_o, 32'h1234_5678);
    chk("t1_d_ack", d_ack_o, 1'b0);
    tick();
    i_cyc_i = 1'b0; i_stb_i = 1'b0;
    #1;
    chk("t1_late_ack_dropped", i_ack_o, 1'b0);
    chk("t1_s_cyc_follows", s_cyc_o, 1'b0);
    s_ack_i = 1'b0;
    tick();
    chk("t1_release_idle", grant_o, 2'b00);

    // Fresh reset, then both masters request together: round-robin alternation.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    i_cyc_i = 1'b1; i_stb_i = 1'b1;
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h0000_0200;
    tick();
    chk("t2_instr_first", grant_o, 2'b01);
    s_ack_i = 1'b1;
    #1;
    chk("t2_d_ack_blocked", d_ack_o, 1'b0);
    s_ack_i = 1'b0;
    tick();
    chk("t2_lock", grant_o, 2'b01);
    i_cyc_i = 1'b0; i_stb_i = 1'b0;
    tick();
    chk("t2_gap_idle", grant_o, 2'b00);
    chk("t2_gap_s_cyc", s_cyc_o, 1'b0);
    tick();
    chk("t2_data_next", grant_o, 2'b10);
    chk("t2_data_adr", s_adr_o, 32'h0000_0200);
    i_cyc_i = 1'b1; i_stb_i = 1'b1;
    d_cyc_i = 1'b0; d_stb_i = 1'b0;
    tick();
    chk("t2_gap2_idle", grant_o, 2'b00);
    d_cyc_i = 1'b1; d_stb_i = 1'b1;
    tick();
    chk("t2_instr_again", grant_o, 2'b01);
    i_cyc_i = 1'b0; i_stb_i = 1'b0;
    d_cyc_i = 1'b0; d_stb_i = 1'b0;
    tick();
    tick();
    chk("t2_all_idle", grant_o, 2'b00);

    // Data write pass-through.
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'b0011;
    d_adr_i = 32'h0000_0100; d_dat_i = 32'hDEAD_BEEF;
    tick();
    chk("t3_grant", grant_o, 2'b10);
    chk("t3_s_we", s_we_o, 1'b1);
    chk("t3_s_sel", s_sel_o, 4'b0011);
    chk("t3_s_adr", s_adr_o, 32'h0000_0100);
    chk("t3_s_dat", s_dat_o, 32'hDEAD_BEEF);
    s_ack_i = 1'b1;
    #1;
    chk("t3_d_ack", d_ack_o, 1'b1);
    chk("t3_i_ack", i_ack_o, 1'b0);
    tick();
    s_ack_i = 1'b0;
    d_cyc_i = 1'b0; d_stb_i = 1'b0; d_we_i = 1'b0;
    tick();

    // Watchdog: slave never responds to a data read.
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_sel_i = 4'hF; d_adr_i = 32'h0000_0300;
    tick();
    chk("t4_grant", grant_o, 2'b10);
    for (int k = 1; k <= 4; k++) begin
      chk("t4_no_err_yet", d_err_o, 1'b0);
      chk("t4_stb_high", s_stb_o, 1'b1);
      tick();
    end
    chk("t4_timeout_err", d_err_o, 1'b1);
    chk("t4_stb_forced_low", s_stb_o, 1'b0);
    chk("t4_i_err_quiet", i_err_o, 1'b0);
    tick();
    chk("t4_single_pulse", d_err_o, 1'b0);
    chk("t4_grant_held", grant_o, 2'b10);
    d_cyc_i = 1'b0; d_stb_i = 1'b0;
    tick();
    chk("t4_release", grant_o, 2'b00);

    // Simultaneous ack and err to the instruction master, then async reset mid-cycle.
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h0000_0080;
    tick();
    chk("t5_grant", grant_o, 2'b01);
    s_ack_i = 1'b1; s_err_i = 1'b1;
    #1;
    chk("t5_err_wins", i_err_o, 1'b1);
    chk("t5_ack_suppressed", i_ack_o, 1'b0);
    chk("t5_d_err_quiet", d_err_o, 1'b0);
    tick();
    s_ack_i = 1'b0; s_err_i = 1'b0;
    #1;
    chk("t5_still_granted", s_cyc_o, 1'b1);
    s_ack_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_s_cyc", s_cyc_o, 1'b0);
    chk("t5_rst_grant", grant_o, 2'b00);
    chk("t5_rst_no_ack", i_ack_o, 1'b0);
    s_ack_i = 1'b0;
    i_cyc_i = 1'b0; i_stb_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_post_idle", grant_o, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
